// File: rtl/despacho_pkg.sv
// Shared definitions for the dispatch unit: instruction fields, opcodes,
// FSM state encoding and tag conventions.
package despacho_pkg;

    localparam int TAG_W      = 3;
    localparam int TAG_PRONTO = 0;   // tag 0: operand value is already available
    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = 3;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_MUL = 4'h5;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;

    localparam logic [1:0] S_PEDE   = 2'd0;
    localparam logic [1:0] S_ESPERA = 2'd1;
    localparam logic [1:0] S_EMITE  = 2'd2;

    typedef enum logic [1:0] {
        CLASSE_NENHUMA,
        CLASSE_ALU,
        CLASSE_MUL,
        CLASSE_ILEGAL
    } classe_t;

    function automatic classe_t classe_de(input logic [3:0] op);
        case (op)
            OP_NOP:                         return CLASSE_NENHUMA;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  return CLASSE_ALU;
            OP_MUL:                         return CLASSE_MUL;
            default:                        return CLASSE_ILEGAL;
        endcase
    endfunction

endpackage

// File: rtl/tabela_status_registradores.sv
// Register status table: per architectural register, the tag of the station
// that will produce it. Issue writes take priority over CDB clears.
module tabela_status_registradores
    import despacho_pkg::*;
#(
    parameter int LARGURA_TAG = TAG_W
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic [REG_ADDR_W-1:0]             Addr_j,
    input  logic [REG_ADDR_W-1:0]             Addr_k,
    output logic [LARGURA_TAG-1:0]            Tag_j,
    output logic [LARGURA_TAG-1:0]            Tag_k,
    input  logic                              Wr_En,
    input  logic [REG_ADDR_W-1:0]             Wr_Addr,
    input  logic [LARGURA_TAG-1:0]            Wr_Tag,
    input  logic                              CDB_Valid,
    input  logic [LARGURA_TAG-1:0]            CDB_Tag,
    output logic [NUM_REGS*LARGURA_TAG-1:0]   Entradas
);

    logic [LARGURA_TAG-1:0] tabela [NUM_REGS];

    assign Tag_j = tabela[Addr_j];
    assign Tag_k = tabela[Addr_k];

    always_ff @(posedge Clock) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (Reset) begin
                tabela[r] <= '0;
            end else if (Wr_En && Wr_Addr == REG_ADDR_W'(r)) begin
                tabela[r] <= Wr_Tag;
            end else if (CDB_Valid && tabela[r] == CDB_Tag) begin
                tabela[r] <= '0;
            end
        end
    end

    always_comb begin
        Entradas = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            Entradas[r*LARGURA_TAG +: LARGURA_TAG] = tabela[r];
        end
    end

endmodule

// File: rtl/unidade_de_despacho.sv
// Tomasulo issue stage: pops one instruction, decodes it, resolves operands
// and allocates the lowest free reservation station of its class.
module unidade_de_despacho #(
    parameter int NUM_RS_ALU = 3,
    parameter int NUM_RS_MUL = 2,
    parameter int TAG_W      = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Empty,
    input  logic [15:0]           Instrucao_Despachada,
    output logic                  Pop,
    output logic [2:0]            Reg_Addr_j,
    output logic [2:0]            Reg_Addr_k,
    input  logic [15:0]           Reg_Data_j,
    input  logic [15:0]           Reg_Data_k,
    input  logic [NUM_RS_ALU-1:0] RS_Busy_Alu,
    input  logic [NUM_RS_MUL-1:0] RS_Busy_Mul,
    input  logic                  CDB_Valid,
    input  logic [TAG_W-1:0]      CDB_Tag,
    input  logic [15:0]           CDB_Value,
    output logic                  Issue_Valid,
    output logic [3:0]            Issue_Op,
    output logic [TAG_W-1:0]      Issue_Tag,
    output logic [15:0]           Issue_Vj,
    output logic [15:0]           Issue_Vk,
    output logic [TAG_W-1:0]      Issue_Qj,
    output logic [TAG_W-1:0]      Issue_Qk,
    output logic                  Stall,
    output logic                  Illegal,
    output logic [1:0]            Estado,
    output logic [8*TAG_W-1:0]    Tabela_Status
);
    import despacho_pkg::*;

    logic [1:0]       estado;
    logic [15:0]      ir;
    logic [3:0]       op;
    logic [2:0]       rd;
    classe_t          classe;
    logic [TAG_W-1:0] rst_j, rst_k;
    logic             livre;
    logic [TAG_W-1:0] tag_livre;
    logic [15:0]      vj, vk;
    logic [TAG_W-1:0] qj, qk;
    logic             emite;
    logic             unused_bits;

    assign op          = ir[OP_MSB:OP_LSB];
    assign rd          = ir[RD_MSB:RD_LSB];
    assign Reg_Addr_j  = ir[RS1_MSB:RS1_LSB];
    assign Reg_Addr_k  = ir[RS2_MSB:RS2_LSB];
    assign unused_bits = ^ir[2:0];
    assign classe      = classe_de(op);
    assign Estado      = estado;

    // Lowest-index free station wins: scan from the top so index 0 is written last.
    always_comb begin
        livre     = 1'b0;
        tag_livre = '0;
        if (classe == CLASSE_ALU) begin
            for (int i = NUM_RS_ALU - 1; i >= 0; i--) begin
                if (!RS_Busy_Alu[i]) begin
                    livre     = 1'b1;
                    tag_livre = TAG_W'(i + 1);
                end
            end
        end else if (classe == CLASSE_MUL) begin
            for (int i = NUM_RS_MUL - 1; i >= 0; i--) begin
                if (!RS_Busy_Mul[i]) begin
                    livre     = 1'b1;
                    tag_livre = TAG_W'(NUM_RS_ALU + i + 1);
                end
            end
        end
    end

    // A producer broadcasting on the CDB in this same cycle forwards its value.
    always_comb begin
        vj = '0;
        qj = rst_j;
        if (rst_j == TAG_W'(TAG_PRONTO)) begin
            vj = Reg_Data_j;
        end else if (CDB_Valid && CDB_Tag == rst_j) begin
            vj = CDB_Value;
            qj = '0;
        end
        vk = '0;
        qk = rst_k;
        if (rst_k == TAG_W'(TAG_PRONTO)) begin
            vk = Reg_Data_k;
        end else if (CDB_Valid && CDB_Tag == rst_k) begin
            vk = CDB_Value;
            qk = '0;
        end
    end

    assign Pop   = (estado == S_PEDE) && !Empty;
    assign emite = (estado == S_EMITE) && livre;
    assign Stall = (estado == S_EMITE) && !livre &&
                   (classe == CLASSE_ALU || classe == CLASSE_MUL);

    tabela_status_registradores #(
        .LARGURA_TAG (TAG_W)
    ) u_tabela (
        .Clock     (Clock),
        .Reset     (Reset),
        .Addr_j    (Reg_Addr_j),
        .Addr_k    (Reg_Addr_k),
        .Tag_j     (rst_j),
        .Tag_k     (rst_k),
        .Wr_En     (emite),
        .Wr_Addr   (rd),
        .Wr_Tag    (tag_livre),
        .CDB_Valid (CDB_Valid),
        .CDB_Tag   (CDB_Tag),
        .Entradas  (Tabela_Status)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado      <= S_PEDE;
            ir          <= '0;
            Issue_Valid <= 1'b0;
            Issue_Op    <= '0;
            Issue_Tag   <= '0;
            Issue_Vj    <= '0;
            Issue_Vk    <= '0;
            Issue_Qj    <= '0;
            Issue_Qk    <= '0;
            Illegal     <= 1'b0;
        end else begin
            Issue_Valid <= 1'b0;
            Illegal     <= 1'b0;
            case (estado)
                S_PEDE: begin
                    if (!Empty) estado <= S_ESPERA;
                end
                S_ESPERA: begin
                    ir     <= Instrucao_Despachada;
                    estado <= S_EMITE;
                end
                S_EMITE: begin
                    case (classe)
                        CLASSE_ALU, CLASSE_MUL: begin
                            if (livre) begin
                                Issue_Valid <= 1'b1;
                                Issue_Op    <= op;
                                Issue_Tag   <= tag_livre;
                                Issue_Vj    <= vj;
                                Issue_Vk    <= vk;
                                Issue_Qj    <= qj;
                                Issue_Qk    <= qk;
                                estado      <= S_PEDE;
                            end
                        end
                        CLASSE_ILEGAL: begin
                            Illegal <= 1'b1;
                            estado  <= S_PEDE;
                        end
                        default: estado <= S_PEDE;
                    endcase
                end
                default: estado <= S_PEDE;
            endcase
        end
    end

endmodule
